// File: rtl/vector_alu_pkg.sv
// Shared types for the vector ALU: opcodes,
// FSM states and decode constants.
package vector_alu_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_ASR = 3'b100,
    OP_LSR = 3'b101,
    OP_LSL = 3'b110,
    OP_AND = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DIV,
    S_DONE
  } state_e;

  localparam logic [OPW-1:0] SEL_DIV = OP_DIV;

endpackage

// File: rtl/vector_alu_if.sv
// Operand/result handshake bundle between
// the vector ALU and its producer/consumer.
interface vector_alu_if
  import vector_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = 4
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] a;
  logic [LANES*WIDTH-1:0] b;
  logic [OPW-1:0]         sel;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] c;
  logic [LANES-1:0]       flag_z;
  logic [LANES-1:0]       flag_n;
  logic [LANES-1:0]       flag_dz;

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, c,
    output flag_z, flag_n, flag_dz
  );

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, c,
    input  flag_z, flag_n, flag_dz
  );

endinterface

// File: rtl/vector_alu_div_lane.sv
// Iterative restoring unsigned divider, one
// quotient bit per cycle, WIDTH cycles per op.
module div_lane #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] q_o,
  output logic             dz_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             dz_q;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;

  // b==0 never restores, so the quotient fills with ones
  always_comb begin
    sh    = {rem_q, quo_q[WIDTH-1]};
    diff  = sh - {1'b0, div_q};
    rem_d = diff[WIDTH] ? sh[WIDTH-1:0]
                        : diff[WIDTH-1:0];
    quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      dz_q   <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= a_i;
      div_q  <= b_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      dz_q   <= (b_i == '0);
    end else if (busy_q) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_q + 1'b1;
      busy_q <= (cnt_q != LAST);
    end
  end

  assign q_o    = quo_d;
  assign dz_o   = dz_q;
  assign done_o = busy_q && (cnt_q == LAST);

endmodule

// File: rtl/vector_alu.sv
// Multi-lane ALU: single-cycle lane ops plus an
// iterative divider, behind a valid/ready FSM.
module vector_alu
  import vector_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = 4
) (
  input logic        clk,
  input logic        rst,
  vector_alu_if.slave bus
);

  localparam int VW = LANES * WIDTH;
  localparam logic [WIDTH-1:0] WLIM =
    WIDTH'(WIDTH);

  state_e           state_q;
  op_e              op_q;
  logic [VW-1:0]    a_q, b_q, c_q;
  logic [LANES-1:0] z_q, n_q, dz_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             accept;
  logic             div_start;
  logic [VW-1:0]    alu_r, div_r, res_d;
  logic [LANES-1:0] div_dz, div_done;
  logic [LANES-1:0] z_d, n_d;

  assign accept    = bus.in_valid && in_ready_q;
  assign div_start = accept && (bus.sel == SEL_DIV);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    div_lane #(.WIDTH(WIDTH)) u_div (
      .clk     (clk),
      .rst     (rst),
      .start_i (div_start),
      .a_i     (bus.a[i*WIDTH +: WIDTH]),
      .b_i     (bus.b[i*WIDTH +: WIDTH]),
      .q_o     (div_r[i*WIDTH +: WIDTH]),
      .dz_o    (div_dz[i]),
      .done_o  (div_done[i])
    );
  end

  function automatic logic [WIDTH-1:0] lane_op(
    input op_e              op,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    r = '0;
    unique case (op)
      OP_ADD: r = x + y;
      OP_SUB: r = x - y;
      OP_MUL: r = x * y;
      OP_ASR: begin
        if (y >= WLIM) r = {WIDTH{x[WIDTH-1]}};
        else           r = $signed(x) >>> y;
      end
      OP_LSR: begin
        if (y >= WLIM) r = '0;
        else           r = x >> y;
      end
      OP_LSL: begin
        if (y >= WLIM) r = '0;
        else           r = x << y;
      end
      OP_AND: r = x & y;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    alu_r = '0;
    z_d   = '0;
    n_d   = '0;
    for (int i = 0; i < LANES; i++) begin
      alu_r[i*WIDTH +: WIDTH] = lane_op(
        op_q,
        a_q[i*WIDTH +: WIDTH],
        b_q[i*WIDTH +: WIDTH]);
    end
    res_d = (state_q == S_DIV) ? div_r : alu_r;
    for (int i = 0; i < LANES; i++) begin
      z_d[i] = (res_d[i*WIDTH +: WIDTH] == '0);
      n_d[i] = res_d[i*WIDTH + WIDTH - 1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      z_q         <= '0;
      n_q         <= '0;
      dz_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          if (accept) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            op_q       <= op_e'(bus.sel);
            in_ready_q <= 1'b0;
            state_q    <= div_start ? S_DIV : S_EXEC;
          end
        end
        (state_q == S_EXEC): begin
          c_q         <= res_d;
          z_q         <= z_d;
          n_q         <= n_d;
          dz_q        <= '0;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        (state_q == S_DIV): begin
          if (&div_done) begin
            c_q         <= res_d;
            z_q         <= z_d;
            n_q         <= n_d;
            dz_q        <= div_dz;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        (state_q == S_DONE): begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_dz   = dz_q;

endmodule
